// File: rtl/udp_rx_pkg.sv
// rtl/udp_rx_pkg.sv - shared UDP header constants and receive FSM encoding
package udp_rx_pkg;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // Header byte offsets, fields transmitted MSB first
    localparam logic [2:0] HDR_SRC_HI  = 3'd0;
    localparam logic [2:0] HDR_SRC_LO  = 3'd1;
    localparam logic [2:0] HDR_DST_HI  = 3'd2;
    localparam logic [2:0] HDR_DST_LO  = 3'd3;
    localparam logic [2:0] HDR_LEN_HI  = 3'd4;
    localparam logic [2:0] HDR_LEN_LO  = 3'd5;
    localparam logic [2:0] HDR_CSUM_HI = 3'd6;
    localparam logic [2:0] HDR_CSUM_LO = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } udp_state_t;

endpackage

// File: rtl/udp_hdr_parse.sv
// rtl/udp_hdr_parse.sv - byte-indexed capture of the UDP header fields
module udp_hdr_parse
    import udp_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic [2:0]  idx,
    input  logic [7:0]  data,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] length
);

    // Checksum bytes are accepted but not stored: the peer always sends zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_port <= '0;
            dst_port <= '0;
            length   <= '0;
        end else if (capture) begin
            case (idx)
                HDR_SRC_HI: src_port[15:8] <= data;
                HDR_SRC_LO: src_port[7:0]  <= data;
                HDR_DST_HI: dst_port[15:8] <= data;
                HDR_DST_LO: dst_port[7:0]  <= data;
                HDR_LEN_HI: length[15:8]   <= data;
                HDR_LEN_LO: length[7:0]    <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - UDP datagram receiver: header check and payload delivery
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT_NUM = 16'hf000
) (
    input  logic        udp_rec_clk,
    input  logic        rst,
    input  logic        ip_data_in_valid,
    input  logic [7:0]  ip_data_in,
    output logic        app_data_out_valid,
    output logic [7:0]  app_data_out,
    output logic [15:0] app_data_length,
    output logic [15:0] udp_src_port,
    output logic        app_data_done,
    output logic        udp_rx_error
);

    udp_state_t  state;
    logic [15:0] cnt;
    logic        hdr_capture;
    logic [2:0]  hdr_idx;
    logic [15:0] hdr_src;
    logic [15:0] hdr_dst;
    logic [15:0] hdr_len;

    assign hdr_capture = ip_data_in_valid && (state == ST_IDLE || state == ST_HEADER);
    assign hdr_idx     = (state == ST_IDLE) ? HDR_SRC_HI : cnt[2:0];

    udp_hdr_parse u_hdr_parse (
        .clk      (udp_rec_clk),
        .rst      (rst),
        .capture  (hdr_capture),
        .idx      (hdr_idx),
        .data     (ip_data_in),
        .src_port (hdr_src),
        .dst_port (hdr_dst),
        .length   (hdr_len)
    );

    always_ff @(posedge udp_rec_clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            app_data_out_valid <= 1'b0;
            app_data_out       <= '0;
            app_data_length    <= '0;
            udp_src_port       <= '0;
            app_data_done      <= 1'b0;
            udp_rx_error       <= 1'b0;
        end else begin
            app_data_out_valid <= 1'b0;
            app_data_done      <= 1'b0;
            udp_rx_error       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ip_data_in_valid) begin
                        cnt   <= 16'd1;
                        state <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (!ip_data_in_valid) begin
                        udp_rx_error <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (cnt[2:0] != HDR_CSUM_LO) begin
                        cnt <= cnt + 16'd1;
                    end else if (hdr_dst != LOCAL_PORT_NUM) begin
                        state <= ST_DRAIN;
                    end else if (hdr_len < UDP_HDR_LEN) begin
                        udp_rx_error <= 1'b1;
                        state        <= ST_DRAIN;
                    end else begin
                        // Subtraction is safe here: length is known to be >= 8
                        app_data_length <= hdr_len - UDP_HDR_LEN;
                        udp_src_port    <= hdr_src;
                        cnt             <= '0;
                        if (hdr_len == UDP_HDR_LEN) begin
                            app_data_done <= 1'b1;
                            state         <= ST_DRAIN;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!ip_data_in_valid) begin
                        udp_rx_error <= 1'b1;
                        state        <= ST_IDLE;
                    end else begin
                        app_data_out_valid <= 1'b1;
                        app_data_out       <= ip_data_in;
                        cnt                <= cnt + 16'd1;
                        if (cnt + 16'd1 == app_data_length) begin
                            app_data_done <= 1'b1;
                            state         <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!ip_data_in_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - directed self-checking bench for udp_rx
module tb_udp_rx;

    logic        udp_rec_clk = 1'b0;
    logic        rst = 1'b1;
    logic        ip_data_in_valid = 1'b0;
    logic [7:0]  ip_data_in = 8'h00;
    logic        app_data_out_valid;
    logic [7:0]  app_data_out;
    logic [15:0] app_data_length;
    logic [15:0] udp_src_port;
    logic        app_data_done;
    logic        udp_rx_error;

    int total = 0;
    int bad = 0;

    udp_rx #(.LOCAL_PORT_NUM(16'hf000)) dut (
        .udp_rec_clk        (udp_rec_clk),
        .rst                (rst),
        .ip_data_in_valid   (ip_data_in_valid),
        .ip_data_in         (ip_data_in),
        .app_data_out_valid (app_data_out_valid),
        .app_data_out       (app_data_out),
        .app_data_length    (app_data_length),
        .udp_src_port       (udp_src_port),
        .app_data_done      (app_data_done),
        .udp_rx_error       (udp_rx_error)
    );

    always #5 udp_rec_clk = ~udp_rec_clk;

    int cyc = 0;
    always @(posedge udp_rec_clk) cyc++;

    logic [7:0]  out_q[$];
    int          out_cyc_q[$];
    int          drv_cyc_q[$];
    logic [15:0] done_len_q[$];
    logic [15:0] done_src_q[$];
    int done_cnt, err_cnt, done_cyc, err_cyc;
    int both_total = 0;

    always @(negedge udp_rec_clk) begin
        if (app_data_out_valid) begin
            out_q.push_back(app_data_out);
            out_cyc_q.push_back(cyc);
        end
        if (app_data_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_len_q.push_back(app_data_length);
            done_src_q.push_back(udp_src_port);
        end
        if (udp_rx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (app_data_done && udp_rx_error) both_total++;
    end

    task automatic clear_mon();
        out_q.delete();
        out_cyc_q.delete();
        drv_cyc_q.delete();
        done_len_q.delete();
        done_src_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        ip_data_in_valid = 1'b1;
        ip_data_in       = b;
        drv_cyc_q.push_back(cyc);
        @(posedge udp_rec_clk);
        #1;
    endtask

    task automatic drive_idle(input int n);
        ip_data_in_valid = 1'b0;
        repeat (n) begin
            @(posedge udp_rec_clk);
            #1;
        end
    endtask

    task automatic drive_hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        drive_byte(src[15:8]);
        drive_byte(src[7:0]);
        drive_byte(dst[15:8]);
        drive_byte(dst[7:0]);
        drive_byte(len[15:8]);
        drive_byte(len[7:0]);
        drive_byte(8'h00);
        drive_byte(8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ip_data_in_valid = 1'b0;
        repeat (2) @(posedge udp_rec_clk);
        #1;
        total++;
        if (app_data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", app_data_out_valid); end
        total++;
        if (app_data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", app_data_out); end
        total++;
        if (app_data_length !== 16'h0000) begin bad++; $display("FAIL reset_len got=%h want=0000", app_data_length); end
        total++;
        if (udp_src_port !== 16'h0000) begin bad++; $display("FAIL reset_src got=%h want=0000", udp_src_port); end
        total++;
        if ({app_data_done, udp_rx_error} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {app_data_done, udp_rx_error}); end
        rst = 1'b0;
        drive_idle(1);
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_mon();
        drive_hdr(16'h1234, 16'hf000, 16'h000c);
        for (int i = 0; i < 4; i++) drive_byte(exp[i]);
        drive_idle(3);
        total++;
        if (out_q.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d want=4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_q[i] !== exp[i]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, out_q[i], exp[i]); end
            total++;
            if (out_cyc_q[i] !== drv_cyc_q[8+i] + 1) begin bad++; $display("FAIL basic_lat%0d got=%0d want=%0d", i, out_cyc_q[i], drv_cyc_q[8+i] + 1); end
        end
        total++;
        if (app_data_length !== 16'd4) begin bad++; $display("FAIL basic_len got=%h want=0004", app_data_length); end
        total++;
        if (udp_src_port !== 16'h1234) begin bad++; $display("FAIL basic_src got=%h want=1234", udp_src_port); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
        total++;
        if (done_cyc !== drv_cyc_q[11] + 1) begin bad++; $display("FAIL basic_done_cyc got=%0d want=%0d", done_cyc, drv_cyc_q[11] + 1); end
        total++;
        if (err_cnt !== 0) begin bad++; $display("FAIL basic_err got=%0d want=0", err_cnt); end
        total++;
        if (app_data_out !== 8'hDD) begin bad++; $display("FAIL basic_hold got=%h want=dd", app_data_out); end
    endtask

    task automatic test_wrong_port();
        clear_mon();
        drive_hdr(16'h1234, 16'hf001, 16'h000c);
        drive_byte(8'hAA); drive_byte(8'hBB); drive_byte(8'hCC); drive_byte(8'hDD);
        drive_idle(1);
        drive_hdr(16'h5678, 16'hf000, 16'h000c);
        drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03); drive_byte(8'h04);
        drive_idle(3);
        total++;
        if (out_q.size() !== 4) begin bad++; $display("FAIL port_count got=%0d want=4", out_q.size()); end
        total++;
        if (out_q[0] !== 8'h01) begin bad++; $display("FAIL port_first got=%h want=01", out_q[0]); end
        total++;
        if (out_q[3] !== 8'h04) begin bad++; $display("FAIL port_last got=%h want=04", out_q[3]); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL port_done got=%0d want=1", done_cnt); end
        total++;
        if (err_cnt !== 0) begin bad++; $display("FAIL port_err got=%0d want=0", err_cnt); end
        total++;
        if (done_src_q[0] !== 16'h5678) begin bad++; $display("FAIL port_src got=%h want=5678", done_src_q[0]); end
    endtask

    task automatic test_bad_len();
        clear_mon();
        drive_hdr(16'h9999, 16'hf000, 16'h0005);
        drive_idle(2);
        total++;
        if (err_cnt !== 1) begin bad++; $display("FAIL short_err got=%0d want=1", err_cnt); end
        total++;
        if (err_cyc !== drv_cyc_q[7] + 1) begin bad++; $display("FAIL short_err_cyc got=%0d want=%0d", err_cyc, drv_cyc_q[7] + 1); end
        total++;
        if (out_q.size() !== 0 || done_cnt !== 0) begin bad++; $display("FAIL short_quiet got=%0d/%0d want=0/0", out_q.size(), done_cnt); end
        total++;
        if (app_data_length !== 16'd4 || udp_src_port !== 16'h5678) begin bad++; $display("FAIL short_hold got=%h/%h want=0004/5678", app_data_length, udp_src_port); end

        clear_mon();
        drive_hdr(16'hABCD, 16'hf000, 16'h0008);
        drive_idle(2);
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL empty_done got=%0d want=1", done_cnt); end
        total++;
        if (done_cyc !== drv_cyc_q[7] + 1) begin bad++; $display("FAIL empty_done_cyc got=%0d want=%0d", done_cyc, drv_cyc_q[7] + 1); end
        total++;
        if (err_cnt !== 0 || out_q.size() !== 0) begin bad++; $display("FAIL empty_quiet got=%0d/%0d want=0/0", err_cnt, out_q.size()); end
        total++;
        if (app_data_length !== 16'd0) begin bad++; $display("FAIL empty_len got=%h want=0000", app_data_length); end
        total++;
        if (udp_src_port !== 16'hABCD) begin bad++; $display("FAIL empty_src got=%h want=abcd", udp_src_port); end
    endtask

    task automatic test_padding();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        clear_mon();
        drive_hdr(16'h4321, 16'hf000, 16'h000c);
        for (int i = 0; i < 4; i++) drive_byte(exp[i]);
        for (int i = 0; i < 18; i++) drive_byte(8'hEE);
        drive_idle(1);
        drive_hdr(16'h0042, 16'hf000, 16'h0009);
        drive_byte(exp[4]);
        drive_idle(3);
        total++;
        if (out_q.size() !== 5) begin bad++; $display("FAIL pad_count got=%0d want=5", out_q.size()); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_q[i] !== exp[i]) begin bad++; $display("FAIL pad_byte%0d got=%h want=%h", i, out_q[i], exp[i]); end
        end
        total++;
        if (done_cnt !== 2 || err_cnt !== 0) begin bad++; $display("FAIL pad_pulses got=%0d/%0d want=2/0", done_cnt, err_cnt); end
        total++;
        if (app_data_length !== 16'd1 || udp_src_port !== 16'h0042) begin bad++; $display("FAIL pad_hdr got=%h/%h want=0001/0042", app_data_length, udp_src_port); end
    endtask

    task automatic test_truncate();
        clear_mon();
        drive_hdr(16'h1234, 16'hf000, 16'h000c);
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        drive_idle(3);
        total++;
        if (out_q.size() !== 2) begin bad++; $display("FAIL trunc_count got=%0d want=2", out_q.size()); end
        total++;
        if (err_cnt !== 1) begin bad++; $display("FAIL trunc_err got=%0d want=1", err_cnt); end
        total++;
        if (err_cyc !== drv_cyc_q[9] + 2) begin bad++; $display("FAIL trunc_err_cyc got=%0d want=%0d", err_cyc, drv_cyc_q[9] + 2); end
        total++;
        if (done_cnt !== 0) begin bad++; $display("FAIL trunc_done got=%0d want=0", done_cnt); end
        total++;
        if (app_data_out !== 8'hBB) begin bad++; $display("FAIL trunc_hold got=%h want=bb", app_data_out); end
    endtask

    task automatic test_rst_payload();
        clear_mon();
        drive_hdr(16'h7777, 16'hf000, 16'h000c);
        drive_byte(8'hAA);
        drive_byte(8'hBB);
        rst = 1'b1;
        ip_data_in_valid = 1'b0;
        @(posedge udp_rec_clk);
        #1;
        total++;
        if ({app_data_out_valid, app_data_out} !== 9'h000) begin bad++; $display("FAIL rst_out got=%h want=000", {app_data_out_valid, app_data_out}); end
        total++;
        if (app_data_length !== 16'h0 || udp_src_port !== 16'h0) begin bad++; $display("FAIL rst_hdr got=%h/%h want=0000/0000", app_data_length, udp_src_port); end
        rst = 1'b0;
        drive_idle(2);
        total++;
        if (done_cnt !== 0 || err_cnt !== 0) begin bad++; $display("FAIL rst_pulses got=%0d/%0d want=0/0", done_cnt, err_cnt); end
        clear_mon();
        drive_hdr(16'h3141, 16'hf000, 16'h000a);
        drive_byte(8'h09);
        drive_byte(8'h08);
        drive_idle(3);
        total++;
        if (out_q.size() !== 2 || out_q[0] !== 8'h09 || out_q[1] !== 8'h08) begin bad++; $display("FAIL rst_next_data got=%0d:%h%h want=2:0908", out_q.size(), out_q[0], out_q[1]); end
        total++;
        if (done_cnt !== 1 || app_data_length !== 16'd2 || udp_src_port !== 16'h3141) begin bad++; $display("FAIL rst_next_hdr got=%0d/%h/%h want=1/0002/3141", done_cnt, app_data_length, udp_src_port); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8];
        exp = '{8'h10, 8'h20, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        clear_mon();
        drive_hdr(16'h1111, 16'hf000, 16'h000b);
        for (int i = 0; i < 3; i++) drive_byte(exp[i]);
        drive_idle(1);
        drive_hdr(16'h2222, 16'hf000, 16'h000d);
        for (int i = 3; i < 8; i++) drive_byte(exp[i]);
        drive_idle(3);
        total++;
        if (out_q.size() !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_q[i] !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d got=%h want=%h", i, out_q[i], exp[i]); end
        end
        total++;
        if (done_cnt !== 2 || err_cnt !== 0) begin bad++; $display("FAIL b2b_pulses got=%0d/%0d want=2/0", done_cnt, err_cnt); end
        total++;
        if (done_len_q[0] !== 16'd3 || done_src_q[0] !== 16'h1111) begin bad++; $display("FAIL b2b_first got=%h/%h want=0003/1111", done_len_q[0], done_src_q[0]); end
        total++;
        if (done_len_q[1] !== 16'd5 || done_src_q[1] !== 16'h2222) begin bad++; $display("FAIL b2b_second got=%h/%h want=0005/2222", done_len_q[1], done_src_q[1]); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_wrong_port();
        test_bad_len();
        test_padding();
        test_truncate();
        test_rst_payload();
        test_back_to_back();
        total++;
        if (both_total !== 0) begin bad++; $display("FAIL done_and_error got=%0d want=0", both_total); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
